// File: rtl/teste_hps_pio_pkg.sv
// Shared constants for the HPS LED output PIO: register map and STATUS layout.
package teste_hps_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/pio_blink_prescaler.sv
// Blink prescaler: a down-counter that reloads from the period and flips phase
// on terminal count. A period of zero parks the blink with phase held high.
module pio_blink_prescaler #(
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    load,
  input  logic [PERIOD_WIDTH-1:0] load_value,
  output logic                    phase
);

  logic [PERIOD_WIDTH-1:0] count_q;

  // A fresh period write wins over a terminal count landing in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      phase   <= 1'b1;
    end else if (load) begin
      count_q <= load_value;
      phase   <= 1'b1;
    end else if (period == '0) begin
      count_q <= '0;
      phase   <= 1'b1;
    end else if (count_q == '0) begin
      count_q <= period;
      phase   <= ~phase;
    end else begin
      count_q <= count_q - PERIOD_WIDTH'(1);
    end
  end

endmodule

// File: rtl/teste_hps_leds_pio.sv
// Avalon-MM output PIO for the board LEDs: data, atomic set/clear, per-bit
// blink enable and a programmable blink period, with registered read data.
module teste_hps_leds_pio
  import teste_hps_pio_pkg::*;
#(
  parameter int               WIDTH        = 10,
  parameter int               PERIOD_WIDTH = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  // Bus handshake: no wait-states, so a write is taken on any edge with
  // chipselect=1 and write_n=0; readdata is valid one cycle after address.
  logic                    wr_en;
  logic [WIDTH-1:0]        wr_bits;
  logic [PERIOD_WIDTH-1:0] wr_period;
  logic                    unused_writedata;

  logic [WIDTH-1:0]        data_q;
  logic [WIDTH-1:0]        blink_en_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic                    phase;
  logic                    period_load;

  logic [WIDTH-1:0]        data_next;
  logic [31:0]             rd_next;
  logic [WIDTH-1:0]        out_next;

  assign wr_en            = chipselect & ~write_n;
  assign wr_bits          = writedata[WIDTH-1:0];
  assign wr_period        = writedata[PERIOD_WIDTH-1:0];
  assign unused_writedata = ^writedata;
  assign period_load      = wr_en && (address == ADDR_PERIOD);

  always_comb begin
    data_next = data_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_next = wr_bits;
        ADDR_OUTSET:   data_next = data_q | wr_bits;
        ADDR_OUTCLEAR: data_next = data_q & ~wr_bits;
        default:       data_next = data_q;
      endcase
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:     rd_next[WIDTH-1:0]        = data_q;
      ADDR_BLINK_EN: rd_next[WIDTH-1:0]        = blink_en_q;
      ADDR_PERIOD:   rd_next[PERIOD_WIDTH-1:0] = period_q;
      ADDR_STATUS:   rd_next[STATUS_PHASE_BIT] = phase;
      default:       rd_next = '0;
    endcase
  end

  // Blinking bits are blanked during the low phase; others pass DATA through.
  assign out_next = data_q & ~(blink_en_q & {WIDTH{~phase}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= RESET_VALUE;
      blink_en_q <= '0;
      period_q   <= '0;
      out_port   <= RESET_VALUE;
      readdata   <= '0;
    end else begin
      data_q   <= data_next;
      out_port <= out_next;
      readdata <= rd_next;
      if (wr_en && (address == ADDR_BLINK_EN)) blink_en_q <= wr_bits;
      if (period_load) period_q <= wr_period;
    end
  end

  pio_blink_prescaler #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .period    (period_q),
    .load      (period_load),
    .load_value(wr_period),
    .phase     (phase)
  );

endmodule

// File: tb/tb_teste_hps_leds_pio.sv
// Bench for the LED output PIO: vector table for the register map, then
// hand sequences for blink timing, period reload priority and async reset.
module tb_teste_hps_leds_pio;

  localparam int WIDTH        = 10;
  localparam int PERIOD_WIDTH = 24;

  logic             clk = 1'b0;
  logic             reset;
  logic             chipselect;
  logic [2:0]       address;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  int n_checks = 0;
  int n_fail   = 0;

  logic        prev_phase;
  logic [31:0] last_period;

  typedef struct {
    logic        cs;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [9:0]  exp_out;
  } vec_t;

  vec_t vecs[22];

  teste_hps_leds_pio #(
    .WIDTH       (WIDTH),
    .PERIOD_WIDTH(PERIOD_WIDTH),
    .RESET_VALUE ('0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .chipselect(chipselect),
    .address   (address),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one bus cycle right after a falling edge; return at the next
  // falling edge so outputs are sampled half a cycle after the active edge.
  task automatic bus(input logic cs, input logic wr, input logic [2:0] a, input logic [31:0] d);
    chipselect = cs;
    write_n    = ~wr;
    address    = a;
    writedata  = d;
    @(negedge clk);
  endtask

  // Write PERIOD=p on the first cycle, then poll STATUS for n-1 cycles.
  // Expected phase after edge e of the segment comes from the half-period
  // length p+1; out_port and STATUS both show the phase one edge late.
  task automatic run_blink(input int p, input int n, input logic [9:0] data);
    for (int e = 0; e < n; e++) begin
      if (e == 0) bus(1'b1, 1'b1, 3'd2, p);
      else        bus(1'b1, 1'b0, 3'd3, 32'h0);
      check("blink_out", 32'(out_port), {22'd0, data[9:1], data[0] & prev_phase});
      if (e == 0) check("period_old", readdata, last_period);
      else        check("status_phase", readdata, {31'd0, prev_phase});
      prev_phase = (p == 0) ? 1'b1 : (((e / (p + 1)) % 2) == 0);
    end
    last_period = p;
  endtask

  initial begin
    //           cs    wr    addr  wdata          exp_rd        exp_out
    vecs[0]  = '{1'b1, 1'b0, 3'd3, 32'h0000_0000, 32'h0000_0001, 10'h000};
    vecs[1]  = '{1'b1, 1'b1, 3'd0, 32'h0000_02A5, 32'h0000_0000, 10'h000};
    vecs[2]  = '{1'b1, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_02A5, 10'h2A5};
    vecs[3]  = '{1'b1, 1'b1, 3'd0, 32'hFFFF_F0F0, 32'h0000_02A5, 10'h2A5};
    vecs[4]  = '{1'b1, 1'b1, 3'd4, 32'h0000_0003, 32'h0000_0000, 10'h0F0};
    vecs[5]  = '{1'b1, 1'b1, 3'd5, 32'h0000_0030, 32'h0000_0000, 10'h0F3};
    vecs[6]  = '{1'b1, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_00C3, 10'h0C3};
    vecs[7]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0000, 32'h0000_0000, 10'h0C3};
    vecs[8]  = '{1'b1, 1'b0, 3'd5, 32'h0000_0000, 32'h0000_0000, 10'h0C3};
    vecs[9]  = '{1'b1, 1'b1, 3'd6, 32'h0000_03FF, 32'h0000_0000, 10'h0C3};
    vecs[10] = '{1'b1, 1'b0, 3'd7, 32'h0000_0000, 32'h0000_0000, 10'h0C3};
    vecs[11] = '{1'b0, 1'b1, 3'd0, 32'h0000_0000, 32'h0000_00C3, 10'h0C3};
    vecs[12] = '{1'b1, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_00C3, 10'h0C3};
    vecs[13] = '{1'b1, 1'b1, 3'd1, 32'h0000_0001, 32'h0000_0000, 10'h0C3};
    vecs[14] = '{1'b1, 1'b0, 3'd1, 32'h0000_0000, 32'h0000_0001, 10'h0C3};
    vecs[15] = '{1'b1, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0000_0000, 10'h0C3};
    vecs[16] = '{1'b1, 1'b0, 3'd2, 32'h0000_0000, 32'h00FF_FFFF, 10'h0C3};
    vecs[17] = '{1'b1, 1'b0, 3'd3, 32'h0000_0000, 32'h0000_0001, 10'h0C3};
    vecs[18] = '{1'b1, 1'b1, 3'd2, 32'h0000_0000, 32'h00FF_FFFF, 10'h0C3};
    vecs[19] = '{1'b1, 1'b0, 3'd2, 32'h0000_0000, 32'h0000_0000, 10'h0C3};
    vecs[20] = '{1'b1, 1'b1, 3'd3, 32'h0000_0000, 32'h0000_0001, 10'h0C3};
    vecs[21] = '{1'b1, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_00C3, 10'h0C3};

    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_out", 32'(out_port), 32'h0);
    check("reset_rd", readdata, 32'h0);
    @(negedge clk);
    check("idle_out", 32'(out_port), 32'h0);
    check("idle_rd", readdata, 32'h0);

    for (int i = 0; i < 22; i++) begin
      bus(vecs[i].cs, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_out", i), 32'(out_port), 32'(vecs[i].exp_out));
    end

    // Blinking on bit0 with DATA all ones; PERIOD=5 lands on a terminal count
    // of the PERIOD=3 run, then PERIOD=0 is written during the low phase.
    prev_phase  = 1'b1;
    last_period = 32'h0;
    bus(1'b1, 1'b1, 3'd0, 32'h0000_03FF);
    run_blink(3, 12, 10'h3FF);
    run_blink(5, 9, 10'h3FF);
    run_blink(0, 6, 10'h3FF);

    // Asynchronous reset in the middle of a half-period.
    bus(1'b1, 1'b1, 3'd0, 32'h0000_0155);
    check("data155_out", 32'(out_port), 32'h0000_03FF);
    run_blink(2, 5, 10'h155);
    check("pre_reset_out", 32'(out_port) & 32'h3FE, 32'h0000_0154);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_out", 32'(out_port), 32'h0);
    check("async_reset_rd", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus(1'b1, 1'b0, 3'd0, 32'h0);
    check("post_reset_data", readdata, 32'h0);
    check("post_reset_out", 32'(out_port), 32'h0);
    bus(1'b1, 1'b0, 3'd1, 32'h0);
    check("post_reset_blink", readdata, 32'h0);
    bus(1'b1, 1'b0, 3'd2, 32'h0);
    check("post_reset_period", readdata, 32'h0);
    bus(1'b1, 1'b0, 3'd3, 32'h0);
    check("post_reset_status", readdata, 32'h1);
    check("post_reset_out2", 32'(out_port), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/teste_hps_leds_pio.md
# teste_hps_leds_pio

Avalon-MM slave output PIO that drives a parallel output port (board LEDs) from the HPS lightweight bridge. It is the write-direction counterpart of the switch input PIO: software writes a data register, atomic set/clear masks, and a per-bit blink mask. A programmable prescaler toggles the blinking bits. It sits in the Qsys system beside the input PIO on the same bridge and clock domain.

## Interface
- `WIDTH`, 10: output port width in bits (1..32).
- `PERIOD_WIDTH`, 24: prescaler width in bits (1..32).
- `RESET_VALUE`, 0: DATA value after reset.
- `clk`  in  1: system clock; all state is updated on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `chipselect`  in  1: slave select; a write is accepted only when it is 1.
- `address`  in  3: word address of the register.
- `write_n`  in  1: active-low write strobe.
- `writedata`  in  32: write data; only bits [WIDTH-1:0] are used, except for PERIOD.
- `readdata`  out  32: registered read data, zero-extended.
- `out_port`  out  WIDTH: registered output to the pins.

## Operation
- A write is accepted on a rising edge where `chipselect=1` and `write_n=0`. There is no wait-state, so every write completes in one cycle.
- Register map by address:
  - 0 DATA, read/write.
  - 1 BLINK_EN, read/write.
  - 2 PERIOD, read/write, PERIOD_WIDTH bits.
  - 3 STATUS, read-only: bit0 = phase, other bits 0.
  - 4 OUTSET, write-only: DATA |= writedata.
  - 5 OUTCLEAR, write-only: DATA &= ~writedata.
  - 6 and 7: reserved. Writes are ignored and reads return 0.
- Reads of OUTSET and OUTCLEAR return 0.
- Prescaler behaviour:
  - When PERIOD≠0, the down-counter decrements each cycle.
  - When the counter is 0, it reloads PERIOD and phase toggles. One full half-period is therefore PERIOD+1 cycles.
  - When PERIOD=0, the blink is disabled: the counter is held at 0 and phase is held at 1.
- Any accepted write to PERIOD loads the counter with the new value and forces phase=1. This takes priority over a terminal count in the same cycle.
- Output equation: `out_port` ← DATA & ~(BLINK_EN & {WIDTH{~phase}}). A blinking bit is shown while phase=1 and forced to 0 while phase=0. Non-blinking bits follow DATA directly.
- Read behaviour:
  - `readdata` is reloaded every cycle from the register selected by `address`. There is no read strobe, and reads have no side effects.
  - Unused upper bits read 0.
- Reset values, applied asynchronously:
  - DATA = RESET_VALUE.
  - BLINK_EN = 0.
  - PERIOD = 0.
  - counter = 0.
  - phase = 1.
  - `out_port` = RESET_VALUE.
  - `readdata` = 0.
- If reset is asserted mid-blink, all state returns to the reset values immediately, with no glitch beyond the asynchronous clear.

## Timing
- Write to DATA, OUTSET, OUTCLEAR or BLINK_EN:
  - The register updates on edge N, where N is the edge that samples the write.
  - `out_port` reflects the change on edge N+1.
- Read latency is 1. `readdata` at edge N+1 holds the register value as it was before edge N. A read and a write to the same address in the same cycle therefore return the old value.
- Phase toggles on the edge where the counter is 0. `out_port` follows on the next edge.
- With PERIOD=P≠0 and no further writes:
  - phase=1 holds for exactly P+1 cycles after the PERIOD write.
  - After that, phase alternates every P+1 cycles.
- OUTSET/OUTCLEAR are single-cycle read-modify-write operations. Back-to-back writes on consecutive cycles must both take effect.

## Structure
- Package `teste_hps_pio_pkg` holds:
  - the address constants ADDR_DATA=0, ADDR_BLINK_EN=1, ADDR_PERIOD=2, ADDR_STATUS=3, ADDR_OUTSET=4, ADDR_OUTCLEAR=5;
  - the STATUS bit index.
- One sub-module, `pio_blink_prescaler`, contains the counter and phase flop. Its inputs are period, load and the period value; its output is phase.
- The register file, write decode, read mux and output register live in the top-level module.

## Test plan
- Reset, then idle → `out_port`=0x000 and `readdata`=0. A read of STATUS returns 0x1.
- Write DATA=0x2A5 → `out_port`=0x2A5 two edges after the write. A read of address 0 returns 0x000002A5.
- With DATA=0x0F0: write OUTSET=0x003, then on the next cycle OUTCLEAR=0x030 → DATA=0x0C3 and `out_port`=0x0C3. Reads of addresses 4 and 5 return 0.
- With DATA=0x3FF and BLINK_EN=0x001, write PERIOD=3 → bit0 is 1 for 4 cycles, then 0 for 4 cycles, repeating. Bits 9:1 stay 1. STATUS bit0 tracks phase.
- During blinking, write PERIOD=0 → phase is forced to 1 and bit0 stays 1. Writing PERIOD=5 in the same cycle as a terminal count → counter reloads to 5, phase=1, and no toggle occurs.
- Assert `reset` asynchronously mid-half-period with DATA=0x155 → `out_port` goes to 0 before the next clock edge, and all registers read back their reset values.
